// File: rtl/sat_pkg.sv
// Shared SAT definitions: phase codes driven to the synchronizer, sequencer
// state encoding and default widths.
package sat_pkg;

    localparam int SAT_CLAUSE_W_DEF = 8;
    localparam int SAT_CYC_W_DEF    = 6;

    typedef logic [1:0] sat_phase_t;

    localparam sat_phase_t SAT_RESET          = 2'b00;
    localparam sat_phase_t SAT_COMPUTE_CLAUSE = 2'b01;
    localparam sat_phase_t SAT_COMPUTE_CNF    = 2'b10;
    localparam sat_phase_t SAT_END_CLAUSE     = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLAUSE,
        ST_CNF,
        ST_ENDC,
        ST_HOLD
    } seq_state_t;

    // HOLD reuses END_CLAUSE so the accumulated CNF stays frozen downstream.
    function automatic sat_phase_t phase_of(input seq_state_t s);
        case (s)
            ST_CLAUSE: phase_of = SAT_COMPUTE_CLAUSE;
            ST_CNF:    phase_of = SAT_COMPUTE_CNF;
            ST_ENDC:   phase_of = SAT_END_CLAUSE;
            ST_HOLD:   phase_of = SAT_END_CLAUSE;
            default:   phase_of = SAT_RESET;
        endcase
    endfunction

endpackage

// File: rtl/sat_seq_cycle_counter.sv
// Loadable down-counter with a zero flag; times the COMPUTE_CLAUSE dwell.
module sat_seq_cycle_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sat_state_sequencer.sv
// SAT phase sequencer: walks CLAUSE/CNF/END_CLAUSE per clause, then holds.
// Optional abort input enabled by defining SAT_SEQ_ABORT_EN.
module sat_state_sequencer
    import sat_pkg::*;
#(
    parameter int CLAUSE_W = SAT_CLAUSE_W_DEF,
    parameter int CYC_W    = SAT_CYC_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
`ifdef SAT_SEQ_ABORT_EN
    input  logic                abort,
`endif
    input  logic [CLAUSE_W-1:0] num_clauses,
    input  logic [CYC_W-1:0]    clause_cycles,
    output logic [1:0]          stateVal,
    output logic [CLAUSE_W-1:0] clause_idx,
    output logic                busy,
    output logic                done
);

    seq_state_t          state_q, state_d;
    logic [CLAUSE_W-1:0] n_q;
    logic [CYC_W-1:0]    c_q;
    logic [CYC_W-1:0]    load_val;
    logic                accept, abort_hit, cnt_load, cnt_dec, cnt_zero;

    // Counter holds remaining CLAUSE cycles minus one; C==0 dwells one cycle.
    function automatic logic [CYC_W-1:0] dwell_load(input logic [CYC_W-1:0] c);
        dwell_load = (c == '0) ? '0 : c - CYC_W'(1);
    endfunction

    sat_seq_cycle_counter #(.W(CYC_W)) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        abort_hit = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        load_val  = dwell_load((state_q == ST_ENDC) ? c_q : clause_cycles);
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (start) begin
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = (num_clauses == '0) ? ST_HOLD : ST_CLAUSE;
                end
            end
            ST_CLAUSE: begin
                if (cnt_zero) state_d = ST_CNF;
                else          cnt_dec = 1'b1;
            end
            ST_CNF: begin
                state_d = (clause_idx == n_q - CLAUSE_W'(1)) ? ST_HOLD : ST_ENDC;
            end
            ST_ENDC: begin
                state_d  = ST_CLAUSE;
                cnt_load = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef SAT_SEQ_ABORT_EN
        if (abort && (state_q != ST_IDLE)) begin
            abort_hit = 1'b1;
            accept    = 1'b0;
            cnt_load  = 1'b0;
            cnt_dec   = 1'b0;
            state_d   = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            stateVal   <= SAT_RESET;
            clause_idx <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            n_q        <= '0;
            c_q        <= '0;
        end else begin
            state_q  <= state_d;
            stateVal <= phase_of(state_d);
            busy     <= (state_d == ST_CLAUSE) || (state_d == ST_CNF) || (state_d == ST_ENDC);
            done     <= (state_d == ST_HOLD) && ((state_q != ST_HOLD) || accept);
            if (accept) begin
                n_q        <= num_clauses;
                c_q        <= clause_cycles;
                clause_idx <= '0;
            end else if (abort_hit) begin
                clause_idx <= '0;
            end else if (state_q == ST_ENDC) begin
                clause_idx <= clause_idx + CLAUSE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sat_state_sequencer.sv
// Bench for sat_state_sequencer: expected phase traces are queued when a run
// is launched and compared cycle by cycle as the DUT produces them.
module tb_sat_state_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] num_clauses;
    logic [5:0] clause_cycles;
    logic [1:0] stateVal;
    logic [7:0] clause_idx;
    logic       busy;
    logic       done;
`ifdef SAT_SEQ_ABORT_EN
    logic       abort;
`endif

    always #5 clk = ~clk;

    sat_state_sequencer #(.CLAUSE_W(8), .CYC_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
`ifdef SAT_SEQ_ABORT_EN
        .abort         (abort),
`endif
        .num_clauses   (num_clauses),
        .clause_cycles (clause_cycles),
        .stateVal      (stateVal),
        .clause_idx    (clause_idx),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        logic [1:0] sv;
        logic [7:0] idx;
        logic       busy;
        logic       done;
        logic       chk_idx;
    } exp_t;

    typedef struct {
        int n;
        int c;
        int hold;
    } run_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic push(input logic [1:0] sv, input int idx, input logic b,
                        input logic d, input logic chk);
        exp_t e;
        e.sv = sv; e.idx = 8'(idx); e.busy = b; e.done = d; e.chk_idx = chk;
        exp_q.push_back(e);
    endtask

    // Expected trace of one run launched by an accepted start, truncated to limit.
    task automatic push_run(input int n, input int c, input int hold,
                            input int limit, output int len);
        exp_t tmp[$];
        exp_t e;
        int   ce;
        ce = (c == 0) ? 1 : c;
        e.chk_idx = 1'b1;
        e.done    = 1'b0;
        for (int i = 0; i < n; i++) begin
            e.idx = 8'(i); e.busy = 1'b1;
            e.sv = 2'b01;
            for (int k = 0; k < ce; k++) tmp.push_back(e);
            e.sv = 2'b10;
            tmp.push_back(e);
            if (i != n - 1) begin
                e.sv = 2'b11;
                tmp.push_back(e);
            end
        end
        e.sv = 2'b11; e.busy = 1'b0; e.idx = (n == 0) ? 8'd0 : 8'(n - 1);
        for (int h = 0; h < hold; h++) begin
            e.done = (h == 0);
            tmp.push_back(e);
        end
        len = 0;
        for (int i = 0; i < tmp.size() && i < limit; i++) begin
            exp_q.push_back(tmp[i]);
            len++;
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (stateVal !== e.sv || busy !== e.busy || done !== e.done ||
                (e.chk_idx && clause_idx !== e.idx)) begin
                n_fail++;
                $display("FAIL cycle_%0d: got stateVal=%b idx=%0d busy=%b done=%b, want stateVal=%b idx=%0d busy=%b done=%b",
                         cyc, stateVal, clause_idx, busy, done, e.sv, e.idx, e.busy, e.done);
            end
        end
    endtask

    task automatic run_seq(input int n, input int c, input int hold);
        int len;
        num_clauses   = 8'(n);
        clause_cycles = 6'(c);
        start         = 1'b1;
        push_run(n, c, hold, 100000, len);
        step();
        start = 1'b0;
        repeat (len - 1) step();
    endtask

    run_t runs[5];
    int   len;

    initial begin
        runs[0] = '{n: 0, c: 5,  hold: 2};
        runs[1] = '{n: 1, c: 0,  hold: 3};
        runs[2] = '{n: 3, c: 4,  hold: 2};
        runs[3] = '{n: 2, c: 1,  hold: 2};
        runs[4] = '{n: 4, c: 63, hold: 2};

        reset = 1'b1; start = 1'b1; num_clauses = 8'd3; clause_cycles = 6'd2;
`ifdef SAT_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        // start under reset must not launch anything
        repeat (2) begin
            push(2'b00, 0, 1'b0, 1'b0, 1'b1);
            step();
        end
        reset = 1'b0; start = 1'b0;
        repeat (10) begin
            push(2'b00, 0, 1'b0, 1'b0, 1'b1);
            step();
        end

        foreach (runs[r]) run_seq(runs[r].n, runs[r].c, runs[r].hold);

        // start pulses and input changes while busy are ignored
        num_clauses = 8'd2; clause_cycles = 6'd3; start = 1'b1;
        push_run(2, 3, 2, 100000, len);
        step();
        for (int j = 2; j <= len; j++) begin
            start         = (j == 3) ? 1'b1 : ((j < len) ? 1'($urandom_range(0, 1)) : 1'b0);
            num_clauses   = 8'($urandom_range(1, 200));
            clause_cycles = 6'($urandom_range(0, 63));
            step();
        end
        start = 1'b0;
        run_seq(1, 2, 2);

        // reset during the second clause's CLAUSE phase
        num_clauses = 8'd3; clause_cycles = 6'd4; start = 1'b1;
        push_run(3, 4, 0, 8, len);
        step();
        start = 1'b0;
        repeat (len - 1) step();
        reset = 1'b1;
        push(2'b00, 0, 1'b0, 1'b0, 1'b1);
        step();
        reset = 1'b0;
        repeat (5) begin
            push(2'b00, 0, 1'b0, 1'b0, 1'b1);
            step();
        end

`ifdef SAT_SEQ_ABORT_EN
        run_seq(1, 2, 2);
        abort = 1'b1; start = 1'b1;
        push(2'b00, 0, 1'b0, 1'b0, 1'b0);
        step();
        abort = 1'b0; start = 1'b0;
        repeat (3) begin
            push(2'b00, 0, 1'b0, 1'b0, 1'b0);
            step();
        end
`endif

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
